// File: rtl/store_merge_unit.sv
// Register-to-memory store path: word stores write directly, byte/halfword
// stores read the enclosing word, merge the addressed lanes and write it back.
module store_merge_unit #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] reg_data,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        align_err,
    output logic [1:0]  state_dbg
);

    // Handshake: start is sampled only while busy=0; an accepted request keeps
    // busy high until its write, then exactly one of done/align_err pulses for
    // one cycle. A start in the done cycle is a fresh, accepted request.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [1:0] LAT_INIT = 2'(MEM_LAT);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  cnt;
    logic        byte_q;
    logic [1:0]  lane_q;
    logic [15:0] data_q;
    logic        req_err;
    logic        accept;
    logic [31:0] merged;

    assign req_err = (size == 2'b11)
                  || (size == 2'b01 && addr[0])
                  || (size == 2'b00 && addr[1:0] != 2'b00);
    assign accept  = (state == IDLE) && start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !req_err) begin
                    state_nxt = (size == 2'b00) ? WRITE : READ;
                end
            end
            READ: begin
                if (cnt == 2'd1) begin
                    state_nxt = WRITE;
                end
            end
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_wr    = (state == WRITE);
        busy      = (state != IDLE);
        state_dbg = state;
    end

    // Only the addressed lane(s) are replaced; the rest come from memory.
    always_comb begin
        merged = mem_rdata;
        if (byte_q) begin
            case (lane_q)
                2'd0:    merged[7:0]   = data_q[7:0];
                2'd1:    merged[15:8]  = data_q[7:0];
                2'd2:    merged[23:16] = data_q[7:0];
                default: merged[31:24] = data_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = data_q;
        end else begin
            merged[15:0] = data_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            align_err <= 1'b0;
            cnt       <= '0;
            byte_q    <= 1'b0;
            lane_q    <= '0;
            data_q    <= '0;
        end else begin
            done      <= (state == WRITE);
            align_err <= accept && req_err;
            if (accept) begin
                byte_q   <= size[1];
                lane_q   <= addr[1:0];
                data_q   <= reg_data[15:0];
                mem_addr <= {addr[31:2], 2'b00};
                if (!req_err) begin
                    if (size == 2'b00) begin
                        mem_wdata <= reg_data;
                    end else begin
                        cnt <= LAT_INIT;
                    end
                end
            end else if (state == READ) begin
                cnt <= cnt - 2'd1;
                if (cnt == 2'd1) begin
                    mem_wdata <= merged;
                end
            end
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: two instances (MEM_LAT 1 and 3) share stimulus,
// each with its own memory, checked every cycle against a schedule model.
module tb_store_merge_unit;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             start    = 1'b0;
    logic [1:0]       size     = 2'b00;
    logic [31:0]      addr     = 32'h0;
    logic [31:0]      reg_data = 32'h0;
    logic [1:0][31:0] maddr;
    logic [1:0][31:0] wdata;
    logic [1:0][31:0] rdata;
    logic [1:0]       wr;
    logic [1:0]       busy;
    logic [1:0]       done;
    logic [1:0]       aerr;
    logic [1:0][1:0]  st;
    logic [1:0][1:0]  st_idle;

    logic [31:0] mem [2][16];
    bit          mem_init_done = 1'b0;
    logic        pl_en  = 1'b0;
    logic [3:0]  pl_idx = 4'h0;
    logic [31:0] pl_val = 32'h0;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // Model: per instance, the accept cycle, write cycle and error cycle of
    // the latest request, plus the address/data the outputs must show.
    int          s_cyc [2];
    int          w_cyc [2];
    int          e_cyc [2];
    logic [31:0] pend_addr [2];
    logic [31:0] pend_wd [2];
    logic [31:0] cur_addr [2];
    logic [31:0] cur_wd [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    store_merge_unit #(.MEM_LAT(1)) u0 (
        .clk(clk), .reset(rst), .start(start), .size(size), .addr(addr),
        .reg_data(reg_data), .mem_addr(maddr[0]), .mem_wr(wr[0]),
        .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .busy(busy[0]),
        .done(done[0]), .align_err(aerr[0]), .state_dbg(st[0])
    );

    store_merge_unit #(.MEM_LAT(3)) u1 (
        .clk(clk), .reset(rst), .start(start), .size(size), .addr(addr),
        .reg_data(reg_data), .mem_addr(maddr[1]), .mem_wr(wr[1]),
        .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .busy(busy[1]),
        .done(done[1]), .align_err(aerr[1]), .state_dbg(st[1])
    );

    assign rdata[0] = mem[0][maddr[0][5:2]];
    assign rdata[1] = mem[1][maddr[1][5:2]];

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 16; j++) mem[i][j] = $urandom();
            mem_init_done = 1'b1;
        end
        for (int i = 0; i < 2; i++)
            if (!rst && wr[i]) mem[i][maddr[i][5:2]] = wdata[i];
        if (pl_en) begin
            mem[0][pl_idx] = pl_val;
            mem[1][pl_idx] = pl_val;
        end
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s u%0d cycle %0d: got %h, expected %h", nm, inst, cyc, act, exp);
        end
    endtask

    function automatic int lat(input int inst);
        return (inst == 0) ? 1 : 3;
    endfunction

    always @(negedge clk) begin
        logic        eb;
        logic        bad;
        logic [31:0] mask;
        int          k;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                s_cyc[i]    = -100;
                w_cyc[i]    = -100;
                e_cyc[i]    = -100;
                cur_addr[i] = 32'h0;
                cur_wd[i]   = 32'h0;
                st_idle[i]  = st[i];
            end else begin
                if (cyc == s_cyc[i] + 1) cur_addr[i] = pend_addr[i];
                if (cyc == w_cyc[i]) cur_wd[i] = pend_wd[i];
            end
            eb = !rst && cyc > s_cyc[i] && cyc <= w_cyc[i];
            chk("busy", i, 32'(busy[i]), 32'(eb));
            chk("dbg_state", i, 32'(st[i] != st_idle[i]), 32'(eb));
            chk("mem_wr", i, 32'(wr[i]), 32'(!rst && cyc == w_cyc[i]));
            chk("done", i, 32'(done[i]), 32'(!rst && cyc == w_cyc[i] + 1));
            chk("align_err", i, 32'(aerr[i]), 32'(!rst && cyc == e_cyc[i]));
            chk("mem_addr", i, maddr[i], cur_addr[i]);
            chk("mem_wdata", i, wdata[i], cur_wd[i]);
            if (!rst && start && !eb) begin
                bad = (size == 2'b11) || (size == 2'b01 && addr[0])
                   || (size == 2'b00 && addr[1:0] != 2'b00);
                s_cyc[i]     = cyc;
                pend_addr[i] = {addr[31:2], 2'b00};
                if (bad) begin
                    e_cyc[i] = cyc + 1;
                    w_cyc[i] = -100;
                end else if (size == 2'b00) begin
                    w_cyc[i]   = cyc + 1;
                    pend_wd[i] = reg_data;
                end else begin
                    w_cyc[i]   = cyc + lat(i) + 1;
                    k          = int'(addr[1:0]);
                    mask       = ((size == 2'b10) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * k);
                    pend_wd[i] = (mem[i][addr[5:2]] & ~mask) | ((reg_data << (8 * k)) & mask);
                end
            end
        end
    end

    task automatic drive(input bit s, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        start = s; size = sz; addr = a; reg_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] v);
        @(posedge clk); #1;
        start = 1'b0; pl_en = 1'b1; pl_idx = idx; pl_val = v;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0;
        #1;
        chk("reset_wr_drop", 0, 32'(wr[0]), 32'h0);
        chk("reset_wr_drop", 1, 32'(wr[1]), 32'h0);
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic directed(input string nm, input int inst, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] pre, input logic [31:0] exp_wd,
                            input logic [31:0] exp_ad, input int exp_dly);
        int t0;
        bit found;
        found = 1'b0;
        preload(a[5:2], pre);
        drive(1'b1, sz, a, d);
        t0 = cyc;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        for (int n = 0; n < 12 && !found; n++) begin
            @(negedge clk);
            if (wr[inst]) begin
                found = 1'b1;
                chk({nm, "_delay"}, inst, 32'(cyc - t0), 32'(exp_dly));
                chk({nm, "_wdata"}, inst, wdata[inst], exp_wd);
                chk({nm, "_addr"}, inst, maddr[inst], exp_ad);
                @(negedge clk);
                chk({nm, "_done"}, inst, 32'(done[inst]), 32'h1);
            end
        end
        chk({nm, "_write_seen"}, inst, 32'(found), 32'h1);
        idle(6);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        directed("word", 0, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'h5555_5555, 32'hDEAD_BEEF, 32'h0000_0010, 1);
        directed("byte", 0, 2'b10, 32'h0000_0013, 32'h0000_00AB, 32'h1122_3344, 32'hAB22_3344, 32'h0000_0010, 2);
        directed("half", 1, 2'b01, 32'h0000_0022, 32'hFFFF_5A5A, 32'h1122_3344, 32'h5A5A_3344, 32'h0000_0020, 4);
        directed("wrap", 1, 2'b10, 32'hFFFF_FFFF, 32'h0000_0077, 32'h1122_3344, 32'h7722_3344, 32'hFFFF_FFFC, 4);

        // Misaligned and reserved requests back to back, then a valid one.
        drive(1'b1, 2'b01, 32'h0000_0021, 32'h1);
        drive(1'b1, 2'b00, 32'h0000_0022, 32'h2);
        @(negedge clk);
        chk("align_half_odd", 0, 32'({aerr[0], wr[0], busy[0]}), 32'h4);
        drive(1'b1, 2'b11, 32'h0000_0020, 32'h3);
        @(negedge clk);
        chk("align_word_off", 0, 32'({aerr[0], wr[0], busy[0]}), 32'h4);
        drive(1'b1, 2'b10, 32'h0000_0024, 32'h4);
        @(negedge clk);
        chk("align_reserved", 1, 32'({aerr[1], wr[1], busy[1]}), 32'h4);
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        chk("after_err_accept", 1, 32'(busy[1]), 32'h1);
        idle(6);

        // Start during READ is ignored; start in the done cycle is taken.
        preload(4'h0, 32'hA5A5_A5A5);
        drive(1'b1, 2'b10, 32'h0000_0041, 32'h0000_003C);
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        drive(1'b1, 2'b00, 32'h0000_0080, 32'h1234_5678);
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        chk("ignored_start_addr", 1, maddr[1], 32'h0000_0040);
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        chk("b2b_merge", 1, wdata[1], 32'hA5A5_3CA5);
        drive(1'b1, 2'b00, 32'h0000_0084, 32'hCAFE_F00D);
        @(negedge clk);
        chk("b2b_done", 1, 32'(done[1]), 32'h1);
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        chk("b2b_new_addr", 1, maddr[1], 32'h0000_0084);
        idle(6);

        // Reset lands in the WRITE cycle of a halfword store on u1.
        preload(4'h3, 32'h0102_0304);
        drive(1'b1, 2'b01, 32'h0000_000E, 32'h0000_BEEF);
        idle(3);
        @(posedge clk); #1;
        chk("pre_reset_write", 1, 32'(wr[1]), 32'h1);
        rst = 1'b1;
        #1;
        chk("reset_mid_wr", 1, 32'({wr[1], busy[1], done[1]}), 32'h0);
        chk("reset_mid_addr", 1, maddr[1], 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("reset_no_write", 1, mem[1][3], 32'h0102_0304);
        idle(2);
        directed("post_reset", 1, 2'b10, 32'h0000_0031, 32'h0000_00EE, 32'h1122_3344, 32'h1122_EE44, 32'h0000_0030, 4);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset($urandom_range(1, 2));
            end else begin
                r  = $urandom_range(0, 9);
                sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
                a  = $urandom();
                if ($urandom_range(0, 9) < 7) begin
                    if (sz == 2'b00) a[1:0] = 2'b00;
                    else if (sz == 2'b01) a[0] = 1'b0;
                end
                drive($urandom_range(0, 2) == 0, sz, a, $urandom());
            end
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded its time limit at cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Register-to-memory store path. It is the opposite direction of the write-back data mux, which carries memory and ALU results into the register file.
- Takes the rt value and a byte address for sw/sh/sb.
- For sub-word stores it does a read-modify-write of the enclosing memory word, merging only the addressed byte or halfword lanes.
- Sits between the register file B output and the single-port data memory. The control FSM starts it and waits for done/align_err.

Parameters:
- MEM_LAT, 1: cycles from a read address being presented (mem_wr=0) to mem_rdata being valid. Legal range 1..3.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- size  in  2  00=word (sw), 01=halfword (sh), 10=byte (sb), 11=reserved
- addr  in  32  byte address of the store
- reg_data  in  32  rt value; the low byte/half is used for sb/sh
- mem_addr  out  32  word-aligned memory address
- mem_wr  out  1  memory write enable; 0 means read
- mem_wdata  out  32  merged write data
- mem_rdata  in  32  memory read data
- busy  out  1  high while a store is in flight
- done  out  1  one-cycle pulse: store completed
- align_err  out  1  one-cycle pulse: misaligned or reserved request, nothing written

Behaviour:
- Reset (async, any time, including mid-operation):
  - State goes to IDLE immediately.
  - mem_addr=0, mem_wr=0, mem_wdata=0, busy=0, done=0, align_err=0; the read-wait counter is cleared.
  - A write in progress is aborted, and mem_wr deasserts asynchronously.
- Byte lanes (little-endian): offset k=addr[1:0] occupies bits [8k+7:8k].
  - Halfword at offset 0 uses bits [15:0]; at offset 2 it uses bits [31:16].
- States: IDLE, READ, WRITE.
- IDLE, start=1: latch size, addr, reg_data; mem_addr <= {addr[31:2],2'b00}. Then:
  - Error check: size=11, or size=01 with addr[0]=1, or size=00 with addr[1:0]!=0 -> align_err=1 next cycle, stay in IDLE, busy stays 0, no memory access.
  - size=00 -> WRITE.
  - size=01 or 10 -> READ; counter loads MEM_LAT.
- READ:
  - busy=1, mem_wr=0, mem_addr held.
  - Counter decrements each cycle. On the cycle it reaches 1, capture mem_rdata, build the merged word, and go to WRITE.
  - Merge rule: the addressed lane(s) take reg_data[7:0] or reg_data[15:0]; all other lanes keep the captured mem_rdata bits.
- WRITE:
  - busy=1, mem_wr=1 for exactly one cycle.
  - mem_wdata is the merged word (byte/half) or reg_data (word).
  - Next state IDLE; done=1 in the following cycle.
- done and align_err are registered single-cycle pulses, never both high. done is high in the first IDLE cycle after WRITE, and a start in that same cycle is accepted.
- Latency (start sampled at cycle T):
  - Word: WRITE at T+1, done at T+2.
  - Byte/half: READ for T+1..T+MEM_LAT, WRITE at T+MEM_LAT+1, done at T+MEM_LAT+2.
  - Error: align_err at T+1.
- start while busy=1 is ignored; changes to addr, size or reg_data after latching have no effect.
- mem_wdata holds its last value outside WRITE. mem_addr holds its last value in IDLE.
- Address wrap: addr=32'hFFFFFFFF with size=10 gives mem_addr=32'hFFFFFFFC and writes lane 3. No carry.

Test Plan:
- Word store, MEM_LAT=1: start with size=00, addr=32'h00000010, reg_data=32'hDEADBEEF -> T+1 mem_wr=1, mem_addr=32'h10, mem_wdata=32'hDEADBEEF, no read cycle; T+2 done=1.
- Byte store: size=10, addr=32'h00000013, reg_data=32'h000000AB, memory word=32'h11223344 -> one READ cycle, then WRITE with mem_wdata=32'hAB223344; done at T+3; busy high at T+1..T+2.
- Halfword store, MEM_LAT=3: size=01, addr=32'h22, reg_data=32'hFFFF5A5A, memory=32'h11223344 -> READ T+1..T+3, WRITE at T+4 with mem_wdata=32'h5A5A3344, done at T+5.
- Alignment: size=01 addr=32'h21; size=00 addr=32'h22; size=11 addr=32'h20 -> each gives align_err=1 at T+1 with mem_wr never asserted and busy=0; a following valid start in the next cycle is accepted.
- Busy/back-to-back: a second start during READ is ignored; a start in the done cycle after a byte store launches a new store whose mem_addr updates at the next edge.
- Reset mid-op: assert reset during WRITE of a byte store -> mem_wr falls immediately, all outputs 0, no done; after release, IDLE accepts start normally.
